csa_accumulator: RTL and testbench

- Parametrised multi-operand accumulator. It folds a stream of WIDTH-bit unsigned operands into redundant carry-save form, one operand per cycle, using a carry-save adder row.
- At end of stream it resolves the sum/carry pair with a chunked, multi-cycle carry-propagate add.
- It presents the full-precision result over a valid/ready handshake.
- Sits between operand producers (e.g. partial-product generators) and consumers needing a binary sum.

---
 rtl/csa_pkg.sv | 44 ++++
 rtl/csa_row.sv | 22 ++
 rtl/csa_accumulator.sv | 161 ++++++++++++++++
 tb/tb_csa_accumulator.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared types and width helpers for the carry-save accumulator.
// Producers and consumers size their buses with the same functions.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int guard_w(input int max_ops);
        return clog2(max_ops);
    endfunction

    function automatic int ow_w(input int width, input int max_ops);
        return width + guard_w(max_ops);
    endfunction

    function automatic int nch_w(
        input int width,
        input int max_ops,
        input int chunk
    );
        return (ow_w(width, max_ops) + chunk - 1) / chunk;
    endfunction

    function automatic int cw_w(input int max_ops);
        return clog2(max_ops) + 1;
    endfunction

endpackage

// File: rtl/csa_row.sv
// W-bit 3:2 compressor. The carry vector comes out already shifted
// into weight position; the carry out of the top bit is dropped.
module csa_row #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum      = a ^ b ^ c;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < W - 1; i++) begin : gen_maj
        assign carry[i+1] = (a[i] & b[i])
                          | (a[i] & c[i])
                          | (b[i] & c[i]);
    end

endmodule

// File: rtl/csa_accumulator.sv
// Multi-operand accumulator: carry-save folding of a stream, then a
// chunked multi-cycle carry-propagate add and a valid/ready result.
module csa_accumulator
    import csa_pkg::*;
#(
    parameter  int WIDTH   = 20,
    parameter  int MAX_OPS = 16,
    parameter  int CHUNK   = 8,
    localparam int GUARD   = guard_w(MAX_OPS),
    localparam int OW      = ow_w(WIDTH, MAX_OPS),
    localparam int NCH     = nch_w(WIDTH, MAX_OPS, CHUNK),
    localparam int CW      = cw_w(MAX_OPS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OW-1:0]    out_sum,
    output logic [CW-1:0]    out_count,
    output logic             out_maxhit
);

    localparam int KW = (NCH > 1) ? clog2(NCH) : 1;

    state_t          state_q;
    state_t          state_d;
    logic [OW-1:0]   s_q;
    logic [OW-1:0]   c_q;
    logic [OW-1:0]   sum_q;
    logic [OW-1:0]   sum_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   cnt_inc;
    logic [KW-1:0]   k_q;
    logic            carry_q;
    logic            valid_q;
    logic            maxhit_q;
    logic            acc;
    logic            at_max;
    logic            last_k;
    logic [OW-1:0]   opnd;
    logic [OW-1:0]   row_s;
    logic [OW-1:0]   row_c;
    logic [OW-1:0]   cand;
    logic [NCH-1:0]  cout;

    assign in_ready = ~reset
                    & ((state_q == IDLE) | (state_q == ACCUM));
    assign acc      = in_valid & in_ready;
    assign opnd     = {{GUARD{1'b0}}, in_data};
    assign cnt_inc  = count_q + CW'(1);
    assign at_max   = (cnt_inc == CW'(MAX_OPS));
    assign last_k   = (k_q == KW'(NCH - 1));

    // c_q already holds the carry vector in its weighted position
    csa_row #(.W(OW)) u_row (
        .a     (s_q),
        .b     (c_q),
        .c     (opnd),
        .sum   (row_s),
        .carry (row_c)
    );

    for (genvar j = 0; j < NCH; j++) begin : gen_chunk
        localparam int LO = j * CHUNK;
        localparam int HI = (LO + CHUNK > OW) ? OW - 1 : LO + CHUNK - 1;
        localparam int WJ = HI - LO + 1;
        logic [WJ:0] r;
        assign r = {1'b0, s_q[HI:LO]}
                 + {1'b0, c_q[HI:LO]}
                 + {{WJ{1'b0}}, carry_q};
        assign cand[HI:LO] = r[WJ-1:0];
        assign cout[j]     = r[WJ];
    end

    always_comb begin
        sum_d = sum_q;
        for (int b = 0; b < OW; b++) begin
            if ((b / CHUNK) == int'(k_q)) sum_d[b] = cand[b];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (acc) state_d = in_last ? RESOLVE : ACCUM;
            end
            ACCUM: begin
                if (acc && (in_last || at_max)) state_d = RESOLVE;
            end
            RESOLVE: begin
                if (last_k) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q      <= '0;
            c_q      <= '0;
            sum_q    <= '0;
            count_q  <= '0;
            k_q      <= '0;
            carry_q  <= 1'b0;
            valid_q  <= 1'b0;
            maxhit_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (acc) begin
                        s_q      <= opnd;
                        c_q      <= '0;
                        count_q  <= CW'(1);
                        maxhit_q <= 1'b0;
                        k_q      <= '0;
                        carry_q  <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (acc) begin
                        s_q      <= row_s;
                        c_q      <= row_c;
                        count_q  <= cnt_inc;
                        maxhit_q <= at_max & ~in_last;
                        k_q      <= '0;
                        carry_q  <= 1'b0;
                    end
                end
                RESOLVE: begin
                    sum_q   <= sum_d;
                    carry_q <= cout[k_q];
                    k_q     <= k_q + KW'(1);
                    if (last_k) valid_q <= 1'b1;
                end
                DONE: begin
                    if (out_ready) valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_valid  = valid_q;
    assign out_sum    = sum_q;
    assign out_count  = count_q;
    assign out_maxhit = maxhit_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator: directed scenarios plus random streams
// checked against an arithmetic sum/count model.
module tb_csa_accumulator;

    localparam int WIDTH   = 20;
    localparam int MAX_OPS = 16;
    localparam int CHUNK   = 8;
    localparam int OW      = 24;
    localparam int CW      = 5;
    localparam int NCH     = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    out_sum;
    logic [CW-1:0]    out_count;
    logic             out_maxhit;

    int checks = 0;
    int errors = 0;

    csa_accumulator #(
        .WIDTH   (WIDTH),
        .MAX_OPS (MAX_OPS),
        .CHUNK   (CHUNK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_count  (out_count),
        .out_maxhit (out_maxhit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int limit, output int lat);
        lat = 0;
        while (!out_valid && lat < limit) begin
            tick();
            lat++;
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 0; in_last = 0;
        in_data = '0; out_ready = 0;
        tick(); tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_in_ready: got %b need 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_out_valid: got %b need 0", out_valid);
        end
        checks++;
        if (out_sum !== 24'h0 || out_count !== 5'd0 || out_maxhit !== 1'b0) begin
            errors++;
            $display("FAIL rst_regs: got %h/%0d/%b need 0/0/0",
                     out_sum, out_count, out_maxhit);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_release_ready: got %b need 1", in_ready);
        end
    endtask

    task automatic test_single();
        int lat;
        send(20'hABCDE, 1'b1);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL single_busy: got %b need 0", in_ready);
        end
        wait_out(10, lat);
        checks++;
        if (out_valid !== 1'b1 || lat != NCH) begin
            errors++;
            $display("FAIL single_latency: got valid=%b lat=%0d need 1/%0d",
                     out_valid, lat, NCH);
        end
        checks++;
        if (out_sum !== 24'h0ABCDE || out_count !== 5'd1 || out_maxhit !== 1'b0) begin
            errors++;
            $display("FAIL single_result: got %h/%0d/%b need 0abcde/1/0",
                     out_sum, out_count, out_maxhit);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_release: got valid=%b ready=%b need 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_continuous();
        int n;
        in_valid = 1'b1; in_data = 20'hFFFFF; in_last = 1'b0;
        tick(); tick();
        in_last = 1'b1;
        tick();
        n = 0;
        while (!out_valid && n < 10) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL cont_busy: got %b need 0", in_ready);
            end
            tick(); n++;
        end
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL cont_done: got valid=%b ready=%b need 1/0",
                     out_valid, in_ready);
        end
        checks++;
        if (out_sum !== 24'h2FFFFD || out_count !== 5'd3) begin
            errors++;
            $display("FAIL cont_result: got %h/%0d need 2ffffd/3",
                     out_sum, out_count);
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL cont_release: got %b need 1", in_ready);
        end
    endtask

    task automatic test_maxhit();
        int lat;
        in_valid = 1'b1; in_data = 20'hFFFFF; in_last = 1'b0;
        repeat (MAX_OPS) tick();
        in_data = 20'h12345;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL max_17th_ready: got %b need 0", in_ready);
        end
        wait_out(10, lat);
        checks++;
        if (out_valid !== 1'b1 || lat != NCH) begin
            errors++;
            $display("FAIL max_latency: got valid=%b lat=%0d need 1/%0d",
                     out_valid, lat, NCH);
        end
        checks++;
        if (out_sum !== 24'hFFFFF0 || out_count !== 5'd16 || out_maxhit !== 1'b1) begin
            errors++;
            $display("FAIL max_result: got %h/%0d/%b need fffff0/16/1",
                     out_sum, out_count, out_maxhit);
        end
        in_valid = 1'b0;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL max_release: got valid=%b ready=%b need 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_gaps();
        int lat;
        send(20'd1, 1'b0);
        repeat (2) tick();
        send(20'd2, 1'b0);
        repeat (2) tick();
        send(20'd3, 1'b1);
        wait_out(10, lat);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 24'h000006 || out_count !== 5'd3) begin
            errors++;
            $display("FAIL gaps_result: got %b/%h/%0d need 1/000006/3",
                     out_valid, out_sum, out_count);
        end
        repeat (5) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sum !== 24'h000006 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL gaps_hold: got %b/%h/%b need 1/000006/0",
                         out_valid, out_sum, in_ready);
            end
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL gaps_release: got valid=%b ready=%b need 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        send(20'h12345, 1'b0);
        send(20'h54321, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 24'h0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got %b/%h/%b need 0/000000/0",
                     out_valid, out_sum, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_count !== 5'd0) begin
            errors++;
            $display("FAIL midrst_hold: got %b/%0d need 0/0", out_valid, out_count);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_ready: got %b need 1", in_ready);
        end
        send(20'd7, 1'b1);
        wait_out(10, lat);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 24'h000007 || out_count !== 5'd1) begin
            errors++;
            $display("FAIL midrst_new: got %b/%h/%0d need 1/000007/1",
                     out_valid, out_sum, out_count);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 20'h80000; in_last = 1'b0;
        tick();
        in_last = 1'b1;
        tick();
        in_data = 20'hFFFFF;
        wait_out(10, lat);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 24'h100000 || out_count !== 5'd2) begin
            errors++;
            $display("FAIL b2b_a: got %b/%h/%0d need 1/100000/2",
                     out_valid, out_sum, out_count);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: got ready=%b valid=%b need 1/0",
                     in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        wait_out(10, lat);
        checks++;
        if (out_valid !== 1'b1 || lat != NCH
            || out_sum !== 24'h0FFFFF || out_count !== 5'd1) begin
            errors++;
            $display("FAIL b2b_b: got %b/lat%0d/%h/%0d need 1/3/0fffff/1",
                     out_valid, lat, out_sum, out_count);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int      len;
            int      lat;
            bit      uselast;
            longint  ref_sum;
            logic [31:0] r;
            logic [OW-1:0] exp_sum;
            len = $urandom_range(1, MAX_OPS);
            if (n == 0) len = MAX_OPS;
            uselast = !(len == MAX_OPS && $urandom_range(0, 1) == 1);
            if (n == 0) uselast = 1'b1;
            ref_sum = 0;
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL rnd_ready s%0d op%0d: got %b need 1", n, i, in_ready);
                end
                r = $urandom();
                ref_sum += longint'(r[WIDTH-1:0]);
                send(r[WIDTH-1:0], (i == len - 1) && uselast);
            end
            exp_sum = ref_sum[OW-1:0];
            wait_out(10, lat);
            checks++;
            if (out_valid !== 1'b1 || lat != NCH) begin
                errors++;
                $display("FAIL rnd_latency s%0d: got %b/%0d need 1/%0d",
                         n, out_valid, lat, NCH);
            end
            checks++;
            if (out_sum !== exp_sum || out_count !== CW'(len)
                || out_maxhit !== (len == MAX_OPS && !uselast)) begin
                errors++;
                $display("FAIL rnd_result s%0d: got %h/%0d/%b need %h/%0d/%b",
                         n, out_sum, out_count, out_maxhit, exp_sum, len,
                         (len == MAX_OPS && !uselast));
            end
            repeat ($urandom_range(0, 3)) tick();
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_continuous();
        test_maxhit();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
